// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//
// Fetch stage sitting between the PC register and decode. It presents the
// current PC to instruction memory, keeps at most one request in flight, and
// latches the returned word into the IF/ID register. It also computes the PC
// register's next value. The PC register has no enable, so holding the PC is
// done by feeding pc_in straight back out on next_pc.
//
// Ports
//   clk             in   1   clock, rising edge
//   clk_reset       in   1   asynchronous, active-low reset
//   pc_in           in  32   current PC from the PC register
//   next_pc         out 32   next PC register value (combinational)
//   imem_req        out  1   request valid to instruction memory
//   imem_addr       out 32   request address (always pc_in)
//   imem_ready      in   1   memory accepts the request this cycle
//   imem_rvalid     in   1   read data valid, one pulse per accepted request
//   imem_rdata      in  32   instruction word
//   redirect_valid  in   1   taken branch/jump: flush IF/ID, restart fetch
//   redirect_pc     in  32   redirect target
//   id_stall        in   1   decode cannot accept a new IF/ID entry
//   if_id_valid     out  1   IF/ID entry valid
//   if_id_instr     out 32   fetched instruction
//   if_id_pc        out 32   address of if_id_instr
//   if_id_pc_plus4  out 32   if_id_pc + 4
//   fetch_fault     out  1   misaligned pc_in while waiting to issue
//   bus_timeout     out  1   sticky: a response took WAIT_TIMEOUT cycles
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0000,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        clk_reset,
    input  logic [31:0] pc_in,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        fetch_fault,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    // Counter value seen during the last permitted waiting cycle; the timeout
    // fires on the WAIT_TIMEOUT-th consecutive cycle without a response.
    localparam logic [7:0] TO_LAST = 8'(WAIT_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_timeout_q;
    logic        timeout_set;

    logic        if_id_valid_q;
    logic [31:0] if_id_instr_q;
    logic [31:0] if_id_pc_q;
    logic [31:0] if_id_pc_plus4_q;

    // Skid register: holds a response that arrived while decode was stalled.
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;

    logic        cap_ok;
    logic        capture;
    logic        skid_load;
    logic [31:0] cap_instr;
    logic [31:0] cap_pc;

    assign cap_ok = !if_id_valid_q || !id_stall;

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        timeout_set = 1'b0;
        capture     = 1'b0;
        skid_load   = 1'b0;
        cap_instr   = imem_rdata;
        cap_pc      = pc_in;
        fetch_fault = 1'b0;
        imem_req    = 1'b0;

        case (state_q)
            ST_REQ: begin
                fetch_fault = (pc_in[1:0] != 2'b00);
                imem_req    = !fetch_fault;
                if (imem_req && imem_ready) begin
                    // A redirect in the issue cycle makes this response stale.
                    state_d = redirect_valid ? ST_DRAIN : ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid) begin
                        state_d = ST_REQ;
                    end else if (cap_ok) begin
                        capture = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    state_d = ST_DRAIN;
                end else if (cnt_q == TO_LAST) begin
                    timeout_set = 1'b1;
                    state_d     = ST_REQ;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_HOLD: begin
                if (redirect_valid) begin
                    state_d = ST_REQ;
                end else if (cap_ok) begin
                    capture   = 1'b1;
                    cap_instr = skid_instr_q;
                    cap_pc    = skid_pc_q;
                    state_d   = ST_REQ;
                end
            end

            ST_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                end else if (cnt_q == TO_LAST) begin
                    timeout_set = 1'b1;
                    state_d     = ST_REQ;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // capture is never raised together with redirect_valid, so a flush always
    // wins and the PC only advances when a word really lands in IF/ID.
    always_comb begin
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (capture) begin
            next_pc = pc_in + 32'd4;
        end else begin
            next_pc = pc_in;
        end
    end

    assign imem_addr = pc_in;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clk_reset) begin
        if (!clk_reset) begin
            state_q       <= ST_REQ;
            cnt_q         <= '0;
            bus_timeout_q <= 1'b0;
            skid_instr_q  <= NOP_INSTR;
            skid_pc_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (timeout_set) begin
                bus_timeout_q <= 1'b1;
            end
            if (skid_load) begin
                skid_instr_q <= imem_rdata;
                skid_pc_q    <= pc_in;
            end
        end
    end

    // IF/ID register. When decode is free and nothing new arrives, the entry
    // it just consumed is retired by clearing valid (a bubble).
    always_ff @(posedge clk or negedge clk_reset) begin
        if (!clk_reset) begin
            if_id_valid_q    <= 1'b0;
            if_id_instr_q    <= NOP_INSTR;
            if_id_pc_q       <= '0;
            if_id_pc_plus4_q <= 32'd4;
        end else if (redirect_valid) begin
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
        end else if (capture) begin
            if_id_valid_q    <= 1'b1;
            if_id_instr_q    <= cap_instr;
            if_id_pc_q       <= cap_pc;
            if_id_pc_plus4_q <= cap_pc + 32'd4;
        end else if (cap_ok) begin
            if_id_valid_q <= 1'b0;
        end
    end

    assign if_id_valid    = if_id_valid_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign bus_timeout    = bus_timeout_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
//
// Directed bench for instr_fetch_stage. The stimulus thread plays the PC
// register and instruction memory, and pushes every IF/ID entry it expects
// decode to consume into a queue. A monitor thread pops and compares each
// entry that decode consumes (if_id_valid with no stall).
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

    logic        clk;
    logic        clk_reset;
    logic [31:0] pc_in;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        fetch_fault;
    logic        bus_timeout;

    int total;
    int bad;
    int txn_num;

    // {instr, pc} of each entry decode is expected to consume, in order
    logic [63:0] exp_q[$];

    instr_fetch_stage #(
        .NOP_INSTR   (32'h0000_0000),
        .WAIT_TIMEOUT(255)
    ) dut (
        .clk           (clk),
        .clk_reset     (clk_reset),
        .pc_in         (pc_in),
        .next_pc       (next_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_stall      (id_stall),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4),
        .fetch_fault   (fetch_fault),
        .bus_timeout   (bus_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: the PC register model loads next_pc at the edge.
    task automatic tick();
        logic [31:0] np;
        #1;
        np = next_pc;
        @(posedge clk);
        #1;
        pc_in = np;
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc);
        exp_q.push_back({instr, pc});
    endtask

    // Scoreboard monitor: decode consumes an entry on each negedge where
    // IF/ID is valid and not stalled.
    task automatic monitor();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (clk_reset && if_id_valid && !id_stall) begin
                txn_num++;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_entry", if_id_instr, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn %0d: instr=%h pc=%h pc4=%h", txn_num,
                             if_id_instr, if_id_pc, if_id_pc_plus4);
                    chk("sb_instr", if_id_instr, e[63:32]);
                    chk("sb_pc", if_id_pc, e[31:0]);
                    chk("sb_pc_plus4", if_id_pc_plus4, e[31:0] + 32'd4);
                end
            end
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        txn_num        = 0;
        clk_reset      = 1'b0;
        pc_in          = 32'd0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_stall       = 1'b0;

        fork
            monitor();
        join_none

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_id_valid", 32'(if_id_valid), 32'd0);
        chk("rst_if_id_instr", if_id_instr, 32'h0000_0000);
        chk("rst_if_id_pc", if_id_pc, 32'd0);
        chk("rst_if_id_pc_plus4", if_id_pc_plus4, 32'd4);
        chk("rst_bus_timeout", 32'(bus_timeout), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd1);
        clk_reset = 1'b1;

        // ---- 1: basic fetch at PC 0
        imem_ready = 1'b1;
        #1;
        chk("t1_imem_addr", imem_addr, 32'd0);
        chk("t1_next_pc_issue", next_pc, 32'd0);
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2008_0005;
        push_exp(32'h2008_0005, 32'd0);
        #1;
        chk("t1_next_pc_capture", next_pc, 32'd4);
        tick();

        // ---- 2: stall with IF/ID full, response goes to the skid register
        imem_rvalid = 1'b0;
        imem_ready  = 1'b1;
        id_stall    = 1'b1;
        #1;
        chk("t2_imem_addr", imem_addr, 32'd4);
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h8C09_0010;
        push_exp(32'h8C09_0010, 32'd4);
        #1;
        chk("t2_next_pc_stalled", next_pc, 32'd4);
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("t2_hold_next_pc", next_pc, 32'd4);
        chk("t2_hold_no_req", 32'(imem_req), 32'd0);
        chk("t2_hold_if_id_kept", if_id_instr, 32'h2008_0005);
        tick();
        id_stall = 1'b0;
        #1;
        chk("t2_release_next_pc", next_pc, 32'd8);
        tick();

        // ---- 3: redirect while waiting -> drain stale response
        imem_ready = 1'b1;
        #1;
        chk("t3_imem_addr", imem_addr, 32'd8);
        tick();
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        #1;
        chk("t3_next_pc_redirect", next_pc, 32'h40);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t3_flush_valid", 32'(if_id_valid), 32'd0);
        chk("t3_flush_instr", if_id_instr, 32'h0000_0000);
        chk("t3_drain_no_req", 32'(imem_req), 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("t3_stale_next_pc", next_pc, 32'h40);
        tick();
        imem_rvalid = 1'b0;
        imem_ready  = 1'b1;
        #1;
        chk("t3_stale_dropped", 32'(if_id_valid), 32'd0);
        chk("t3_req_resumes", 32'(imem_req), 32'd1);
        chk("t3_imem_addr", imem_addr, 32'h40);
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00A0_0093;
        push_exp(32'h00A0_0093, 32'h40);
        tick();

        // ---- 4: misaligned PC -> fetch_fault, then redirect clears it
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0002;
        tick();
        redirect_valid = 1'b0;
        imem_ready     = 1'b1;
        #1;
        chk("t4_fault", 32'(fetch_fault), 32'd1);
        chk("t4_fault_no_req", 32'(imem_req), 32'd0);
        chk("t4_fault_next_pc", next_pc, 32'd2);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0010;
        #1;
        chk("t4_fault_level", 32'(fetch_fault), 32'd1);
        chk("t4_redirect_next_pc", next_pc, 32'h10);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t4_fault_cleared", 32'(fetch_fault), 32'd0);
        chk("t4_req_resumes", 32'(imem_req), 32'd1);
        chk("t4_imem_addr", imem_addr, 32'h10);
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0100_0113;
        push_exp(32'h0100_0113, 32'h10);
        tick();

        // ---- 5: no response for 255 cycles -> bus_timeout
        imem_rvalid = 1'b0;
        imem_ready  = 1'b1;
        tick();
        imem_ready = 1'b0;
        repeat (254) tick();
        #1;
        chk("t5_no_timeout_yet", 32'(bus_timeout), 32'd0);
        chk("t5_still_waiting", 32'(imem_req), 32'd0);
        tick();
        chk("t5_timeout_set", 32'(bus_timeout), 32'd1);
        chk("t5_back_in_req", 32'(imem_req), 32'd1);
        chk("t5_next_pc_held", next_pc, 32'h14);
        // late response arrives in REQ: ignored
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFFFF_FFFF;
        tick();
        imem_rvalid = 1'b0;
        repeat (3) tick();
        chk("t5_timeout_sticky", 32'(bus_timeout), 32'd1);
        chk("t5_late_rsp_ignored", 32'(if_id_valid), 32'd0);

        // ---- 6: asynchronous reset during WAIT
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        #1;
        chk("t6_in_wait", 32'(imem_req), 32'd0);
        clk_reset = 1'b0;
        pc_in     = 32'd0;
        #1;
        chk("t6_async_req", 32'(imem_req), 32'd1);
        chk("t6_async_timeout_clr", 32'(bus_timeout), 32'd0);
        chk("t6_async_pc4", if_id_pc_plus4, 32'd4);
        tick();
        clk_reset   = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAAD_F00D;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("t6_old_rsp_ignored", 32'(if_id_valid), 32'd0);
        chk("t6_still_req", 32'(imem_req), 32'd1);
        chk("t6_next_pc", next_pc, 32'd0);
        repeat (2) tick();

        chk("sb_all_consumed", 32'(exp_q.size()), 32'd0);
        chk("sb_txn_count", 32'(txn_num), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
